// File: rtl/fetch_pc_stage_pkg.sv
// Shared fetch-stage definitions: FSM encoding, default vectors and the next-PC select code.
// Decode and hazard logic import the same defaults.
package fetch_pc_stage_pkg;

    localparam logic [0:0] FETCH_BOOT = 1'b0;
    localparam logic [0:0] FETCH_RUN  = 1'b1;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_REDIRECT = 2'd0,
        SEL_HOLD     = 2'd1,
        SEL_BUBBLE   = 2'd2,
        SEL_ADVANCE  = 2'd3
    } pc_sel_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface fetch_pc_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_pc_stage_pc_next_sel.sv
// Combinational next-PC selection: redirect > stall > imem wait > sequential advance.
// Outside RUN everything holds, so a redirect during BOOT has no effect.
module pc_next_sel
    import fetch_pc_stage_pkg::*;
(
    input  logic        run,
    input  logic        stall,
    input  logic        br_sel,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        imem_ready,
    input  logic [31:0] pc,
    output pc_sel_e     sel,
    output logic [31:0] pc_next,
    output logic        misalign
);

    logic [31:0] raw_target;

    // br_sel belongs to the older instruction (in EX), so it beats a jump in ID.
    assign raw_target = br_sel ? br_target : jump_target;

    always_comb begin
        sel      = SEL_HOLD;
        pc_next  = pc;
        misalign = 1'b0;
        if (run) begin
            if (br_sel || jump) begin
                sel      = SEL_REDIRECT;
                pc_next  = align_word(raw_target);
                misalign = |raw_target[1:0];
            end else if (stall) begin
                sel = SEL_HOLD;
            end else if (!imem_ready) begin
                sel = SEL_BUBBLE;
            end else begin
                sel     = SEL_ADVANCE;
                pc_next = pc + 32'd4;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC, fills IF/ID, applies redirects with a one-bubble
// penalty and keeps a sticky misalignment flag plus a saturating redirect counter.
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  br_sel,
    input  logic [31:0]           br_target,
    input  logic                  jump,
    input  logic [31:0]           jump_target,
    fetch_pc_stage_if.master      imem,
    output logic [31:0]           ifid_instr,
    output logic [31:0]           ifid_pc4,
    output logic                  ifid_valid,
    output logic                  misalign_err,
    output logic [CNT_W-1:0]      redirect_cnt
);

    logic [0:0]       state_reg;
    logic [31:0]      pc_reg;
    logic [31:0]      instr_reg;
    logic [31:0]      pc4_reg;
    logic             valid_reg;
    logic             misalign_reg;
    logic [CNT_W-1:0] cnt_reg;

    pc_sel_e          sel;
    logic [31:0]      pc_next;
    logic             misalign;

    pc_next_sel u_pc_next_sel (
        .run         (state_reg == FETCH_RUN),
        .stall       (stall),
        .br_sel      (br_sel),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .imem_ready  (imem.imem_ready),
        .pc          (pc_reg),
        .sel         (sel),
        .pc_next     (pc_next),
        .misalign    (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= FETCH_BOOT;
            pc_reg       <= RESET_VEC;
            instr_reg    <= NOP_INSTR;
            pc4_reg      <= 32'h0000_0000;
            valid_reg    <= 1'b0;
            misalign_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg <= FETCH_RUN;
            pc_reg    <= pc_next;
            case (sel)
                SEL_REDIRECT: begin
                    // The word fetched this cycle is wrong-path; replace it with a bubble.
                    instr_reg <= NOP_INSTR;
                    valid_reg <= 1'b0;
                    if (misalign) misalign_reg <= 1'b1;
                    if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
                end
                SEL_BUBBLE: begin
                    instr_reg <= NOP_INSTR;
                    valid_reg <= 1'b0;
                end
                SEL_ADVANCE: begin
                    instr_reg <= imem.imem_rdata;
                    pc4_reg   <= pc_next;
                    valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign imem.imem_addr = pc_reg;
    assign ifid_instr     = instr_reg;
    assign ifid_pc4       = pc4_reg;
    assign ifid_valid     = valid_reg;
    assign misalign_err   = misalign_reg;
    assign redirect_cnt   = cnt_reg;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed vector bench for fetch_pc_stage: table of per-edge expectations plus
// hand-written BOOT, asynchronous reset and counter-saturation sequences.
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_sel;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        misalign_err;
    logic [15:0] redirect_cnt;

    fetch_pc_stage_if imem_bus ();

    fetch_pc_stage #(
        .RESET_VEC (32'h0040_0000),
        .NOP_INSTR (32'h0000_0000),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .br_sel       (br_sel),
        .br_target    (br_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem         (imem_bus),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .misalign_err (misalign_err),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br_sel;
        logic [31:0] br_target;
        logic        jump;
        logic [31:0] jump_target;
        logic        ready;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
        logic [15:0] exp_cnt;
        logic        exp_mis;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid, input logic [15:0] cnt,
                             input logic mis);
        chk({tag, ".imem_addr"}, imem_bus.imem_addr, pc);
        chk({tag, ".ifid_instr"}, ifid_instr, instr);
        chk({tag, ".ifid_pc4"}, ifid_pc4, pc4);
        chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, valid});
        chk({tag, ".redirect_cnt"}, {16'b0, redirect_cnt}, {16'b0, cnt});
        chk({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, mis});
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        br_sel      = 1'b0;
        jump        = 1'b0;
        br_target   = 32'h0;
        jump_target = 32'h0;
    endtask

    initial begin
        //            stall br  br_target      jmp jump_target    rdy rdata          exp_pc         exp_instr      exp_pc4        vld cnt    mis
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2008_0005, 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1, 16'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1111_1111, 32'h0040_0008, 32'h1111_1111, 32'h0040_0008, 1'b1, 16'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0,         1'b1, 32'h2222_2222, 32'h0040_0100, 32'h0,         32'h0040_0008, 1'b0, 16'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h3333_3333, 32'h0040_0104, 32'h3333_3333, 32'h0040_0104, 1'b1, 16'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0300, 1'b1, 32'h4444_4444, 32'h0040_0200, 32'h0,         32'h0040_0104, 1'b0, 16'd2, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h5555_5555, 32'h0040_0204, 32'h5555_5555, 32'h0040_0204, 1'b1, 16'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h6666_6666, 32'h0040_0204, 32'h5555_5555, 32'h0040_0204, 1'b1, 16'd2, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h6666_6666, 32'h0040_0204, 32'h5555_5555, 32'h0040_0204, 1'b1, 16'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h6666_6666, 32'h0040_0204, 32'h5555_5555, 32'h0040_0204, 1'b1, 16'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h6666_6666, 32'h0040_0204, 32'h0,         32'h0040_0204, 1'b0, 16'd2, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h6666_6666, 32'h0040_0204, 32'h0,         32'h0040_0204, 1'b0, 16'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'h6666_6666, 32'hFFFF_FFFC, 32'h0,         32'h0040_0204, 1'b0, 16'd3, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h7777_7777, 32'h0000_0000, 32'h7777_7777, 32'h0000_0000, 1'b1, 16'd3, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h0040_0102, 1'b0, 32'h0,         1'b1, 32'h9999_9999, 32'h0040_0100, 32'h0,         32'h0000_0000, 1'b0, 16'd4, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8888_8888, 32'h0040_0104, 32'h8888_8888, 32'h0040_0104, 1'b1, 16'd4, 1'b1};

        rst_n = 1'b0;
        idle_inputs();
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h2008_0005;
        #12;
        chk_state("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 16'd0, 1'b0);
        $display("reset: pc=%h valid=%b", imem_bus.imem_addr, ifid_valid);

        // A misaligned redirect presented during BOOT must leave no trace.
        @(negedge clk);
        rst_n     = 1'b1;
        br_sel    = 1'b1;
        br_target = 32'h0040_0102;
        edge_sample();
        chk_state("boot", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 16'd0, 1'b0);
        $display("boot: pc=%h valid=%b cnt=%0d mis=%b", imem_bus.imem_addr, ifid_valid, redirect_cnt, misalign_err);

        for (int i = 0; i < NVEC; i++) begin
            stall               = vecs[i].stall;
            br_sel              = vecs[i].br_sel;
            br_target           = vecs[i].br_target;
            jump                = vecs[i].jump;
            jump_target         = vecs[i].jump_target;
            imem_bus.imem_ready = vecs[i].ready;
            imem_bus.imem_rdata = vecs[i].rdata;
            edge_sample();
            chk_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_pc4,
                      vecs[i].exp_valid, vecs[i].exp_cnt, vecs[i].exp_mis);
            $display("vec %0d: pc=%h instr=%h pc4=%h valid=%b cnt=%0d mis=%b", i, imem_bus.imem_addr,
                     ifid_instr, ifid_pc4, ifid_valid, redirect_cnt, misalign_err);
        end

        // Reset asserted mid-stall, between edges: outputs must clear without a clock edge.
        idle_inputs();
        stall = 1'b1;
        edge_sample();
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("async_reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 16'd0, 1'b0);
        $display("async_reset: pc=%h valid=%b cnt=%0d mis=%b", imem_bus.imem_addr, ifid_valid, redirect_cnt, misalign_err);

        // 2^16 + 3 back-to-back redirects: counter must stop at all-ones.
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        edge_sample();
        br_sel    = 1'b1;
        br_target = 32'h0040_0000;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat.pre", {16'b0, redirect_cnt}, 32'h0000_FFFE);
        $display("saturation: after 65534 redirects cnt=%h", redirect_cnt);
        repeat (5) @(posedge clk);
        #1;
        chk("sat.cnt", {16'b0, redirect_cnt}, 32'h0000_FFFF);
        chk("sat.pc", imem_bus.imem_addr, 32'h0040_0000);
        $display("saturation: after 65539 redirects cnt=%h", redirect_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
